des_f_sbox_sequencer: RTL and testbench

Initiator side of the S-box select/finish handshake for the DES f-function datapath. It accepts the 48-bit E(R) xor K word and splits it into eight 6-bit lookups. It drives the select strobes of the eight S-box responders (S1..S8), collects their 4-bit results once all finish flags are high, and applies the DES P permutation. It returns the 32-bit f-function result to the round controller with a start/done handshake.

---
 rtl/des_pkg.sv | 28 ++
 rtl/des_p_permute.sv | 18 +
 rtl/des_f_sbox_sequencer.sv | 124 ++++++++++++
 tb/tb_des_f_sbox_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES definitions for the f-function datapath.
// Holds the S-box geometry, the f-function word widths, the sequencer
// state encoding and the P permutation table.
// P_TABLE[i] is the DES input bit (1 = MSB) that feeds DES output bit i+1.
package des_pkg;

    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 4;
    localparam int SBOX_NUM   = 8;

    localparam int F_IN_W  = SBOX_NUM * SBOX_IN_W;   // 48
    localparam int F_OUT_W = SBOX_NUM * SBOX_OUT_W;  // 32

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_PERMUTE = 2'd3
    } seq_state_t;

    localparam int unsigned P_TABLE [F_OUT_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

endpackage

// File: rtl/des_p_permute.sv
// DES P permutation, purely combinational.
// Ports:
//   din  [31:0]  input word, bit 31 = DES bit 1
//   dout [31:0]  permuted word, bit 31 = DES bit 1
// DES bit k (1-based, MSB first) lives at vector index 32-k.
module des_p_permute
    import des_pkg::*;
(
    input  logic [F_OUT_W-1:0] din,
    output logic [F_OUT_W-1:0] dout
);

    for (genvar g = 0; g < F_OUT_W; g++) begin : g_bit
        localparam int SRC = F_OUT_W - int'(P_TABLE[g]);
        assign dout[F_OUT_W-1-g] = din[SRC];
    end

endmodule

// File: rtl/des_f_sbox_sequencer.sv
// Initiator side of the S-box select/finish handshake for the DES f-function.
// Latches E(R) xor K, strobes all eight S-box responders, collects their
// 4-bit results once every finish flag is high, and returns P(S1..S8).
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   f_start, f_input    one-cycle request and 48-bit E(R) xor K word
//   f_busy              high while a request is in flight
//   f_done, f_error     one-cycle completion / timeout pulses
//   f_output            32-bit f-function result (valid with f_done)
//   sbox_input          latched request word, S1 on [47:42] ... S8 on [5:0]
//   sbox_select         per-box select strobes, bit 7 = S1
//   sbox_output         S-box results, S1 on [31:28] ... S8 on [3:0]
//   sbox_finish         per-box finish flags, bit 7 = S1
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for f_start
// ST_ISSUE   | select strobes high for one cycle, wait counter cleared
// ST_WAIT    | waiting for all eight finish flags, counting towards timeout
// ST_PERMUTE | result captured, f_done pulses with the permuted result
module des_f_sbox_sequencer
    import des_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                f_start,
    input  logic [F_IN_W-1:0]   f_input,
    output logic                f_busy,
    output logic                f_done,
    output logic                f_error,
    output logic [F_OUT_W-1:0]  f_output,
    output logic [F_IN_W-1:0]   sbox_input,
    output logic [SBOX_NUM-1:0] sbox_select,
    input  logic [F_OUT_W-1:0]  sbox_output,
    input  logic [SBOX_NUM-1:0] sbox_finish
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [F_OUT_W-1:0] capture_q;
    logic               load_input;
    logic               load_capture;
    logic               all_finished;

    assign all_finished = (sbox_finish == {SBOX_NUM{1'b1}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            sbox_input <= '0;
            capture_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (load_input) begin
                sbox_input <= f_input;
            end
            if (load_capture) begin
                capture_q <= sbox_output;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        sbox_select  = '0;
        f_busy       = 1'b0;
        f_done       = 1'b0;
        f_error      = 1'b0;
        load_input   = 1'b0;
        load_capture = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (f_start) begin
                    load_input = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                sbox_select = {SBOX_NUM{1'b1}};
                f_busy      = 1'b1;
                wait_cnt_d  = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                f_busy = 1'b1;
                if (all_finished) begin
                    load_capture = 1'b1;
                    state_d      = ST_PERMUTE;
                end else if (wait_cnt_q == CNT_LAST) begin
                    f_error = 1'b1;
                    f_busy  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_PERMUTE: begin
                f_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // capture_q only changes on the WAIT -> PERMUTE edge, so the permuted
    // result is new exactly in the PERMUTE cycle (together with f_done) and
    // holds through errors and idle time. Reset clears it, giving zero out.
    des_p_permute u_p_permute (
        .din  (capture_q),
        .dout (f_output)
    );

endmodule

// File: tb/tb_des_f_sbox_sequencer.sv
module tb_des_f_sbox_sequencer;

    logic        clk;
    logic        rst;
    logic        f_start;
    logic [47:0] f_input;
    logic        f_busy;
    logic        f_done;
    logic        f_error;
    logic [31:0] f_output;
    logic [47:0] sbox_input;
    logic [7:0]  sbox_select;
    logic [31:0] sbox_output;
    logic [7:0]  sbox_finish;

    int n_tests = 0;
    int n_fail  = 0;

    des_f_sbox_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_start     (f_start),
        .f_input     (f_input),
        .f_busy      (f_busy),
        .f_done      (f_done),
        .f_error     (f_error),
        .f_output    (f_output),
        .sbox_input  (sbox_input),
        .sbox_select (sbox_select),
        .sbox_output (sbox_output),
        .sbox_finish (sbox_finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DES S-boxes, row 0 in the top 64 bits, entry 0 in the top nibble.
    localparam logic [255:0] SBOX_TAB [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [31:0] sbox_all(input logic [47:0] din);
        logic [31:0]  res;
        logic [255:0] tab;
        logic [5:0]   six;
        int           idx;
        res = '0;
        for (int b = 0; b < 8; b++) begin
            tab = SBOX_TAB[b];
            six = din[47-6*b -: 6];
            idx = 16 * int'({six[5], six[0]}) + int'(six[4:1]);
            res[31-4*b -: 4] = tab[255-4*idx -: 4];
        end
        return res;
    endfunction

    // Behavioural 1-cycle responders: registered result, finish follows
    // select by one cycle. fin_mask holds chosen flags low, fin_force
    // drives all flags high regardless of select.
    logic [7:0]  fin_q     = '0;
    logic [31:0] sout_q    = '0;
    logic [7:0]  fin_mask  = '0;
    logic        fin_force = 1'b0;

    always @(posedge clk) begin
        fin_q  <= sbox_select;
        sout_q <= sbox_all(sbox_input);
    end

    assign sbox_finish = (fin_q & ~fin_mask) | {8{fin_force}};
    assign sbox_output = sout_q;

    typedef struct {
        logic [47:0] din;
        logic [31:0] exp_s;
        logic [31:0] exp_f;
    } vec_t;

    vec_t vecs [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Starts in the current cycle (cycle 0), returns positioned in cycle 4,
    // which is the first cycle a follow-on start may be issued.
    task automatic run_txn(input vec_t v, input string tag);
        f_input = v.din;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        check({tag, " c1 select"}, 64'(sbox_select), 64'(8'hFF));
        check({tag, " c1 sbox_input"}, 64'(sbox_input), 64'(v.din));
        check({tag, " c1 busy"}, 64'(f_busy), 64'(1));
        tick();
        check({tag, " c2 select"}, 64'(sbox_select), 64'(0));
        check({tag, " c2 sbox results"}, 64'(sbox_output), 64'(v.exp_s));
        check({tag, " c2 done"}, 64'(f_done), 64'(0));
        tick();
        check({tag, " c3 done"}, 64'(f_done), 64'(1));
        check({tag, " c3 f_output"}, 64'(f_output), 64'(v.exp_f));
        check({tag, " c3 busy"}, 64'(f_busy), 64'(0));
        check({tag, " c3 error"}, 64'(f_error), 64'(0));
        tick();
        check({tag, " c4 done"}, 64'(f_done), 64'(0));
        check({tag, " c4 f_output hold"}, 64'(f_output), 64'(v.exp_f));
    endtask

    initial begin
        vecs[0] = '{din: 48'h6117BA866527, exp_s: 32'h5C82B597, exp_f: 32'h234AA9BB};
        vecs[1] = '{din: 48'h000000000000, exp_s: 32'hEFA72C4D, exp_f: 32'hD8D8DBBC};
        vecs[2] = '{din: 48'hFFFFFFFFFFFF, exp_s: 32'hD9CE3DCB, exp_f: 32'h38DBF9CB};

        rst     = 1'b1;
        f_start = 1'b0;
        f_input = '0;
        tick();
        tick();
        check("reset busy", 64'(f_busy), 64'(0));
        check("reset done", 64'(f_done), 64'(0));
        check("reset error", 64'(f_error), 64'(0));
        check("reset f_output", 64'(f_output), 64'(0));
        check("reset sbox_input", 64'(sbox_input), 64'(0));
        check("reset select", 64'(sbox_select), 64'(0));
        rst = 1'b0;
        tick();

        // Table vectors, issued back-to-back on the cycle after each done.
        for (int i = 0; i < 3; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: S8 never finishes; error on the fourth WAIT cycle.
        tick();
        fin_mask = 8'h01;
        f_input  = vecs[0].din;
        f_start  = 1'b1;
        tick();
        f_start = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            check($sformatf("timeout c%0d error", c), 64'(f_error), 64'(0));
            check($sformatf("timeout c%0d busy", c), 64'(f_busy), 64'(1));
        end
        tick();
        check("timeout c5 error", 64'(f_error), 64'(1));
        check("timeout c5 busy", 64'(f_busy), 64'(0));
        check("timeout c5 done", 64'(f_done), 64'(0));
        check("timeout c5 f_output", 64'(f_output), 64'(vecs[2].exp_f));
        tick();
        check("timeout c6 error", 64'(f_error), 64'(0));
        check("timeout c6 done", 64'(f_done), 64'(0));
        check("timeout c6 busy", 64'(f_busy), 64'(0));
        check("timeout c6 f_output", 64'(f_output), 64'(vecs[2].exp_f));
        fin_mask = '0;
        tick();

        // Start while busy is ignored; result belongs to the first input.
        f_input = vecs[0].din;
        f_start = 1'b1;
        tick();
        f_input = vecs[2].din;
        check("busy-start c1 sbox_input", 64'(sbox_input), 64'(vecs[0].din));
        tick();
        check("busy-start c2 sbox_input", 64'(sbox_input), 64'(vecs[0].din));
        check("busy-start c2 sbox results", 64'(sbox_output), 64'(vecs[0].exp_s));
        f_start = 1'b0;
        tick();
        check("busy-start c3 done", 64'(f_done), 64'(1));
        check("busy-start c3 f_output", 64'(f_output), 64'(vecs[0].exp_f));
        tick();
        check("busy-start c4 busy", 64'(f_busy), 64'(0));
        check("busy-start c4 select", 64'(sbox_select), 64'(0));
        tick();

        // Async reset in WAIT while all finish flags are high.
        f_input = vecs[2].din;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        tick();
        check("rst-wait finish high", 64'(sbox_finish), 64'(8'hFF));
        rst = 1'b1;
        #1;
        check("rst-wait busy", 64'(f_busy), 64'(0));
        check("rst-wait done", 64'(f_done), 64'(0));
        check("rst-wait error", 64'(f_error), 64'(0));
        check("rst-wait f_output", 64'(f_output), 64'(0));
        check("rst-wait sbox_input", 64'(sbox_input), 64'(0));
        check("rst-wait select", 64'(sbox_select), 64'(0));
        tick();
        rst       = 1'b0;
        fin_force = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("rst-after c%0d done", c), 64'(f_done), 64'(0));
            check($sformatf("rst-after c%0d busy", c), 64'(f_busy), 64'(0));
            check($sformatf("rst-after c%0d f_output", c), 64'(f_output), 64'(0));
        end
        fin_force = 1'b0;
        tick();
        tick();
        run_txn(vecs[0], "post-rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
